// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM state type,
// word-access constant and default datapath widths.
package mem_stage_pkg;

    // Default datapath and D-cache word-address widths.
    localparam int BIT_W_DEFAULT  = 32;
    localparam int ADDR_W_DEFAULT = 30;

    // Byte-offset width of a word access: the D-cache address starts at this bit.
    localparam int MEM_REQ_WORD = 2;

    // D-cache access tracking states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Word-wide D-cache request/stall bus between the MEM stage (master)
// and the data cache (slave).
interface mem_stage_if
    import mem_stage_pkg::*;
#(
    parameter int BIT_W  = BIT_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
);

    logic              DCACHE_ren;
    logic              DCACHE_wen;
    logic [ADDR_W-1:0] DCACHE_addr;
    logic [BIT_W-1:0]  DCACHE_wdata;
    logic [BIT_W-1:0]  DCACHE_rdata;
    logic              DCACHE_stall;

    modport master (
        output DCACHE_ren,
        output DCACHE_wen,
        output DCACHE_addr,
        output DCACHE_wdata,
        input  DCACHE_rdata,
        input  DCACHE_stall
    );

    modport slave (
        input  DCACHE_ren,
        input  DCACHE_wen,
        input  DCACHE_addr,
        input  DCACHE_wdata,
        output DCACHE_rdata,
        output DCACHE_stall
    );

endinterface

// File: rtl/mem_stage_dcache.sv
// D-cache access control for the MEM stage: tracks an outstanding request,
// blocks re-issue of a completed access while the pipeline is frozen, and
// keeps the load data that completed during such a freeze.
module mem_dcache_if
    import mem_stage_pkg::*;
#(
    parameter int BIT_W = BIT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             memrd_in,
    input  logic             memwr_in,
    input  logic             stall_in,
    input  logic             dcache_stall,
    input  logic [BIT_W-1:0] dcache_rdata,
    output logic             req,
    output logic             mem_stall,
    output logic [BIT_W-1:0] ld_data
);

    mem_state_e       state;
    mem_state_e       state_next;
    logic             need;
    logic             done;
    logic [BIT_W-1:0] rdata_q;

    // Request generation: a completed access is not re-issued while held, and reset drops it at once.
    always_comb begin
        need      = memrd_in | memwr_in;
        req       = need & (state != HOLD) & ~rst;
        done      = req & ~dcache_stall;
        mem_stall = req & dcache_stall;
        ld_data   = (state == HOLD) ? rdata_q : dcache_rdata;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: ACCESS follows a cache miss, HOLD parks a finished access during a freeze.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (need && dcache_stall) begin
                    state_next = ACCESS;
                end else if (done && stall_in) begin
                    state_next = HOLD;
                end
            end
            ACCESS: begin
                if (!dcache_stall) begin
                    state_next = stall_in ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (!stall_in) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture load data on completion so it survives a freeze in HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (done && memrd_in) begin
            rdata_q <= dcache_rdata;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: D-cache access for loads/stores, write-back value
// selection, MEM/WB register and unregistered forwarding data for EX.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int BIT_W  = BIT_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIT_W-1:0] alu_result_in,
    input  logic [BIT_W-1:0] mem_wdata_in,
    input  logic [4:0]       rd_in,
    input  logic [BIT_W-1:0] PC_plus_4_in,
    input  logic             memrd_in,
    input  logic             memwr_in,
    input  logic             mem2reg_in,
    input  logic             regwr_in,
    input  logic             jump_in,
    input  logic             stall_in,
    mem_stage_if.master      dcache,
    output logic             mem_stall,
    output logic [BIT_W-1:0] wb_data,
    output logic [4:0]       wb_rd,
    output logic             wb_regwr,
    output logic [BIT_W-1:0] fwd_dat_noblock,
    output logic [4:0]       fwd_rd_noblock,
    output logic             fwd_regwr_noblock
);

    logic             req;
    logic [BIT_W-1:0] ld_data;
    logic [BIT_W-1:0] wb_sel;
    logic             adv;

    mem_dcache_if #(
        .BIT_W (BIT_W)
    ) u_dcache_ctrl (
        .clk          (clk),
        .rst          (rst),
        .memrd_in     (memrd_in),
        .memwr_in     (memwr_in),
        .stall_in     (stall_in),
        .dcache_stall (dcache.DCACHE_stall),
        .dcache_rdata (dcache.DCACHE_rdata),
        .req          (req),
        .mem_stall    (mem_stall),
        .ld_data      (ld_data)
    );

    // Cache bus drive: byte address bits [1:0] are dropped, misalignment is not trapped.
    always_comb begin
        dcache.DCACHE_ren   = req & memrd_in;
        dcache.DCACHE_wen   = req & memwr_in;
        dcache.DCACHE_addr  = alu_result_in[ADDR_W+MEM_REQ_WORD-1:MEM_REQ_WORD];
        dcache.DCACHE_wdata = mem_wdata_in;
    end

    // Write-back source select and forwarding; load data is never forwarded from MEM.
    always_comb begin
        fwd_dat_noblock   = jump_in ? PC_plus_4_in : alu_result_in;
        fwd_rd_noblock    = rd_in;
        fwd_regwr_noblock = regwr_in & ~mem2reg_in;
        wb_sel            = mem2reg_in ? ld_data : fwd_dat_noblock;
        adv               = ~mem_stall & ~stall_in;
    end

    // MEM/WB register: advances only when neither this stage nor the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_data  <= '0;
            wb_rd    <= '0;
            wb_regwr <= 1'b0;
        end else if (adv) begin
            wb_data  <= wb_sel;
            wb_rd    <= rd_in;
            wb_regwr <= regwr_in;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus random
// instruction streams against a transaction-level model of the stage
// and a behavioural data-cache model.
module tb_mem_stage;

    localparam int BIT_W  = 32;
    localparam int ADDR_W = 30;
    localparam int MAX_CYCLES = 60;

    logic              clk = 1'b0;
    logic              rst;
    logic [BIT_W-1:0]  alu_result_in;
    logic [BIT_W-1:0]  mem_wdata_in;
    logic [4:0]        rd_in;
    logic [BIT_W-1:0]  PC_plus_4_in;
    logic              memrd_in;
    logic              memwr_in;
    logic              mem2reg_in;
    logic              regwr_in;
    logic              jump_in;
    logic              stall_in;
    logic              mem_stall;
    logic [BIT_W-1:0]  wb_data;
    logic [4:0]        wb_rd;
    logic              wb_regwr;
    logic [BIT_W-1:0]  fwd_dat_noblock;
    logic [4:0]        fwd_rd_noblock;
    logic              fwd_regwr_noblock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [BIT_W-1:0] mem_model [logic [ADDR_W-1:0]];
    logic [BIT_W-1:0] exp_wb_data;
    logic [4:0]       exp_wb_rd;
    logic             exp_wb_regwr;

    mem_stage_if #(.BIT_W(BIT_W), .ADDR_W(ADDR_W)) dbus ();

    mem_stage #(.BIT_W(BIT_W), .ADDR_W(ADDR_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .alu_result_in     (alu_result_in),
        .mem_wdata_in      (mem_wdata_in),
        .rd_in             (rd_in),
        .PC_plus_4_in      (PC_plus_4_in),
        .memrd_in          (memrd_in),
        .memwr_in          (memwr_in),
        .mem2reg_in        (mem2reg_in),
        .regwr_in          (regwr_in),
        .jump_in           (jump_in),
        .stall_in          (stall_in),
        .dcache            (dbus),
        .mem_stall         (mem_stall),
        .wb_data           (wb_data),
        .wb_rd             (wb_rd),
        .wb_regwr          (wb_regwr),
        .fwd_dat_noblock   (fwd_dat_noblock),
        .fwd_rd_noblock    (fwd_rd_noblock),
        .fwd_regwr_noblock (fwd_regwr_noblock)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Backing store of the modelled cache; unwritten words read a fixed pattern.
    function automatic logic [BIT_W-1:0] mem_read(input logic [ADDR_W-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return 32'hC0DE_0000 ^ {2'b00, a};
    endfunction

    task automatic check_output(input string tag, input logic [BIT_W-1:0] obs,
                                input logic [BIT_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one instruction until the stage advances it; miss = cache busy cycles,
    // stall_cycles = leading cycles of global freeze, rst_cycle = cycle index carrying reset.
    task automatic apply_stimulus(input logic rd_op, input logic wr_op, input logic m2r,
                                  input logic rw, input logic jmp,
                                  input logic [BIT_W-1:0] alu, input logic [BIT_W-1:0] wd,
                                  input logic [BIT_W-1:0] pc4, input logic [4:0] rd,
                                  input int miss, input int stall_cycles, input int rst_cycle);
        int               cyc = 0;
        int               miss_left = miss;
        int               completions = 0;
        bit               advanced = 1'b0;
        bit               acc_done = 1'b0;
        logic             need;
        logic             exp_req;
        logic             cstall;
        logic [ADDR_W-1:0] addr;
        logic [BIT_W-1:0] ld_val = '0;
        need = rd_op | wr_op;
        addr = alu[ADDR_W+1:2];
        while (!advanced) begin
            @(negedge clk);
            memrd_in      = rd_op;
            memwr_in      = wr_op;
            mem2reg_in    = m2r;
            regwr_in      = rw;
            jump_in       = jmp;
            alu_result_in = alu;
            mem_wdata_in  = wd;
            PC_plus_4_in  = pc4;
            rd_in         = rd;
            stall_in      = (cyc < stall_cycles);
            rst           = (cyc == rst_cycle);
            exp_req       = need & ~acc_done & ~rst;
            cstall        = (miss_left > 0);
            dbus.DCACHE_stall = cstall;
            dbus.DCACHE_rdata = (exp_req & ~cstall & rd_op) ? mem_read(addr) : $urandom;
            #1;
            check_output("ren", {31'b0, dbus.DCACHE_ren}, {31'b0, exp_req & rd_op});
            check_output("wen", {31'b0, dbus.DCACHE_wen}, {31'b0, exp_req & wr_op});
            check_output("mem_stall", {31'b0, mem_stall}, {31'b0, exp_req & cstall});
            check_output("fwd_dat", fwd_dat_noblock, jmp ? pc4 : alu);
            check_output("fwd_rd", {27'b0, fwd_rd_noblock}, {27'b0, rd});
            check_output("fwd_regwr", {31'b0, fwd_regwr_noblock}, {31'b0, rw & ~m2r});
            if (exp_req) begin
                check_output("addr", {2'b00, dbus.DCACHE_addr}, {2'b00, addr});
                check_output("wdata", dbus.DCACHE_wdata, wd);
            end
            @(posedge clk);
            if (rst) begin
                acc_done     = 1'b0;
                exp_wb_data  = '0;
                exp_wb_rd    = '0;
                exp_wb_regwr = 1'b0;
            end else begin
                if (exp_req && !cstall) begin
                    acc_done = 1'b1;
                    completions++;
                    if (rd_op) ld_val = mem_read(addr);
                    if (wr_op) mem_model[addr] = wd;
                end else if (exp_req && cstall) begin
                    miss_left--;
                end
                if (!(exp_req && cstall) && !stall_in) begin
                    advanced     = 1'b1;
                    exp_wb_data  = m2r ? ld_val : (jmp ? pc4 : alu);
                    exp_wb_rd    = rd;
                    exp_wb_regwr = rw;
                end
            end
            #1;
            check_output("wb_data", wb_data, exp_wb_data);
            check_output("wb_rd", {27'b0, wb_rd}, {27'b0, exp_wb_rd});
            check_output("wb_regwr", {31'b0, wb_regwr}, {31'b0, exp_wb_regwr});
            cyc++;
            if (!advanced && cyc > MAX_CYCLES) begin
                check_output("advance_timeout", 32'd0, 32'd1);
                break;
            end
        end
        if (need) check_output("completions", completions, 32'd1);
    endtask

    // Directed scenarios followed by a random instruction stream.
    initial begin
        rst = 1'b1;
        alu_result_in = '0; mem_wdata_in = '0; rd_in = '0; PC_plus_4_in = '0;
        memrd_in = 1'b1; memwr_in = 1'b0; mem2reg_in = 1'b1; regwr_in = 1'b1;
        jump_in = 1'b0; stall_in = 1'b0;
        dbus.DCACHE_stall = 1'b0; dbus.DCACHE_rdata = 32'h1234_5678;

        // Reset state: no request under reset, MEM/WB cleared.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_ren", {31'b0, dbus.DCACHE_ren}, 32'd0);
        check_output("rst_mem_stall", {31'b0, mem_stall}, 32'd0);
        check_output("rst_wb_data", wb_data, 32'd0);
        check_output("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
        check_output("rst_wb_regwr", {31'b0, wb_regwr}, 32'd0);
        exp_wb_data = '0; exp_wb_rd = '0; exp_wb_regwr = 1'b0;

        // ALU op, load hit, store miss, load hit under freeze, jal, reset mid-access.
        apply_stimulus(0, 0, 0, 1, 0, 32'h10, 32'h0, 32'h0, 5'd5, 0, 0, -1);
        check_output("t1_wb_data", wb_data, 32'h10);
        mem_model[30'h10] = 32'hDEAD_BEEF;
        apply_stimulus(1, 0, 1, 1, 0, 32'h40, 32'h0, 32'h0, 5'd6, 0, 0, -1);
        check_output("t2_wb_data", wb_data, 32'hDEAD_BEEF);
        apply_stimulus(0, 1, 0, 0, 0, 32'h80, 32'hCAFE_F00D, 32'h0, 5'd0, 3, 0, -1);
        check_output("t3_mem", mem_read(30'h20), 32'hCAFE_F00D);
        apply_stimulus(1, 0, 1, 1, 0, 32'h80, 32'h0, 32'h0, 5'd7, 0, 2, -1);
        check_output("t4_wb_data", wb_data, 32'hCAFE_F00D);
        apply_stimulus(0, 0, 0, 1, 1, 32'h55, 32'h0, 32'h104, 5'd1, 0, 0, -1);
        check_output("t5_wb_data", wb_data, 32'h104);
        apply_stimulus(1, 0, 1, 1, 0, 32'h41, 32'h0, 32'h0, 5'd9, 3, 0, 1);
        apply_stimulus(0, 1, 0, 0, 0, 32'h44, 32'h0BAD_0001, 32'h0, 5'd0, 2, 1, 2);

        // Random stream over a small address window so loads observe earlier stores.
        for (int i = 0; i < 200; i++) begin
            int               kind;
            logic [BIT_W-1:0] a;
            kind = $urandom_range(0, 3);
            a    = 32'h100 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
            case (kind)
                0: apply_stimulus(0, 0, 0, 1'($urandom), 0, $urandom, $urandom, $urandom,
                                  5'($urandom), $urandom_range(0, 1), $urandom_range(0, 2), -1);
                1: apply_stimulus(1, 0, 1, 1, 0, a, $urandom, $urandom,
                                  5'($urandom), $urandom_range(0, 3), $urandom_range(0, 2), -1);
                2: apply_stimulus(0, 1, 0, 0, 0, a, $urandom, $urandom,
                                  5'($urandom), $urandom_range(0, 3), $urandom_range(0, 2), -1);
                default: apply_stimulus(0, 0, 0, 1, 1, $urandom, $urandom, $urandom,
                                  5'($urandom), 0, $urandom_range(0, 2), -1);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
